// File: rtl/pop_graph_render.sv
// rtl/pop_graph_render.sv - population history bar graph renderer
// Purpose: counts alive cells per generation, keeps a DEPTH-entry history of
//          scaled counts and renders it as a bar graph with white axes.
//          pix_out follows hcount_in/vcount_in by exactly two cycles.
// Ports:
//   clk_in          only clock
//   rst_in          synchronous active-high reset
//   hcount_in       current pixel column
//   vcount_in       current pixel row
//   alive_valid_in  qualifies is_alive_in
//   is_alive_in     current cell is alive
//   frame_end_in    one-cycle pulse closing the current generation's count
//   pix_out         graph pixel colour, 12'h000 outside the graph
//   last_count_out  most recently committed raw count
//   peak_count_out  largest raw count committed since reset
module pop_graph_render #(
    parameter int          GRAPH_X     = 800,
    parameter int          GRAPH_Y     = 100,
    parameter int          DEPTH       = 200,
    parameter int          HEIGHT      = 200,
    parameter int          CNT_W       = 16,
    parameter int          SCALE_SHIFT = 4,
    parameter logic [11:0] BAR_COLOR   = 12'h0F0
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [10:0]      hcount_in,
    input  logic [9:0]       vcount_in,
    input  logic             alive_valid_in,
    input  logic             is_alive_in,
    input  logic             frame_end_in,
    output logic [11:0]      pix_out,
    output logic [CNT_W-1:0] last_count_out,
    output logic [CNT_W-1:0] peak_count_out
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so index sums up to 2*DEPTH-1 never overflow.
    localparam int PW = AW + 1;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [AW-1:0]    WR_LAST = AW'(DEPTH - 1);
    localparam logic [PW-1:0]    DEPTH_P = PW'(DEPTH);
    localparam logic [31:0]      X_AXIS  = 32'(GRAPH_X);
    localparam logic [31:0]      X_END   = 32'(GRAPH_X + DEPTH);
    localparam logic [31:0]      Y_TOP   = 32'(GRAPH_Y);
    localparam logic [31:0]      Y_AXIS  = 32'(GRAPH_Y + HEIGHT);

    logic [CNT_W-1:0] acc;
    logic [AW-1:0]    wr_ptr;
    logic [PW-1:0]    fill;

    logic             sample;
    logic [CNT_W-1:0] close_cnt;
    logic [CNT_W-1:0] scaled;
    logic [9:0]       bar_h;

    // The closing count already includes this cycle's sample.
    assign sample    = alive_valid_in && is_alive_in;
    assign close_cnt = (sample && (acc != CNT_MAX)) ? acc + 1'b1 : acc;
    assign scaled    = close_cnt >> SCALE_SHIFT;
    assign bar_h     = (32'(scaled) >= 32'(HEIGHT)) ? 10'(HEIGHT) : 10'(scaled);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            acc            <= '0;
            wr_ptr         <= '0;
            fill           <= '0;
            last_count_out <= '0;
            peak_count_out <= '0;
        end else if (frame_end_in) begin
            acc            <= {{(CNT_W-1){1'b0}}, sample};
            wr_ptr         <= (wr_ptr == WR_LAST) ? '0 : wr_ptr + 1'b1;
            if (fill != DEPTH_P)
                fill <= fill + 1'b1;
            last_count_out <= close_cnt;
            if (close_cnt > peak_count_out)
                peak_count_out <= close_cnt;
        end else begin
            acc <= close_cnt;
        end
    end

    // History RAM: one write port, one registered read port, no reset.
    logic [9:0]    hist [0:DEPTH-1];
    logic [AW-1:0] rd_addr;
    logic [9:0]    rd_data;

    always_ff @(posedge clk_in) begin
        if (frame_end_in && !rst_in)
            hist[wr_ptr] <= bar_h;
        rd_data <= hist[rd_addr];
    end

    // Stage 1: region decode and read address.
    logic [31:0]   hx;
    logic [31:0]   vy;
    logic          in_col;
    logic          in_rows;
    logic          is_axis;
    logic          bar_ok;
    logic [PW-1:0] col;
    logic [PW-1:0] base;
    logic [PW-1:0] base_mod;
    logic [PW-1:0] sum;
    logic [9:0]    row_off;

    assign hx      = 32'(hcount_in);
    assign vy      = 32'(vcount_in);
    assign in_col  = (hx > X_AXIS) && (hx <= X_END);
    assign in_rows = (vy >= Y_TOP) && (vy < Y_AXIS);
    assign is_axis = ((hx == X_AXIS) && (vy >= Y_TOP) && (vy <= Y_AXIS)) ||
                     ((vy == Y_AXIS) && (hx >= X_AXIS) && (hx <= X_END));
    assign col     = PW'(hx - X_AXIS - 32'd1);
    // Oldest sample sits at (wr_ptr - fill) mod DEPTH; DEPTH is added first
    // so the subtraction never goes negative.
    assign base     = {1'b0, wr_ptr} + DEPTH_P - fill;
    assign base_mod = (base >= DEPTH_P) ? base - DEPTH_P : base;
    assign sum      = base_mod + col;
    assign rd_addr  = in_col ? AW'((sum >= DEPTH_P) ? sum - DEPTH_P : sum) : '0;
    assign bar_ok   = in_col && in_rows && (col < fill);
    // Distance from the bottom plot row; a bar of height n lights offsets 0..n-1.
    assign row_off  = 10'(Y_AXIS - 32'd1 - vy);

    logic       s1_axis;
    logic       s1_bar;
    logic [9:0] s1_row;

    // Stage 2: compare against the read history value and register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_axis <= 1'b0;
            s1_bar  <= 1'b0;
            s1_row  <= '0;
            pix_out <= 12'h000;
        end else begin
            s1_axis <= is_axis;
            s1_bar  <= bar_ok;
            s1_row  <= row_off;
            if (s1_axis)
                pix_out <= 12'hFFF;
            else if (s1_bar && (s1_row < rd_data))
                pix_out <= BAR_COLOR;
            else
                pix_out <= 12'h000;
        end
    end
endmodule

// File: doc/pop_graph_render.md
POP_GRAPH_RENDER -- requirements
Module: pop_graph_render

Interface
REQ-001 Parameter GRAPH_X, default 800, SHALL be the pixel column of the graph's left axis.
REQ-002 Parameter GRAPH_Y, default 100, SHALL be the pixel row of the graph's top edge.
REQ-003 Parameter DEPTH, default 200 (range 2..1023), SHALL be the number of history samples and the plot width in pixels.
REQ-004 Parameter HEIGHT, default 200 (range 1..1023), SHALL be the plot height in pixels.
REQ-005 Parameter CNT_W, default 16, SHALL be the width of the per-frame alive-cell counter.
REQ-006 Parameter SCALE_SHIFT, default 4, SHALL set how far a frame count is right-shifted to give a bar height.
REQ-007 Parameter BAR_COLOR, default 12'h0F0, SHALL be the bar pixel colour; axes are 12'hFFF.
REQ-008 clk_in, input, 1: the only clock.
REQ-009 rst_in, input, 1: reset, synchronous and active-high.
REQ-010 hcount_in, input, 11: current pixel column.
REQ-011 vcount_in, input, 10: current pixel row.
REQ-012 alive_valid_in, input, 1: qualifies is_alive_in this cycle.
REQ-013 is_alive_in, input, 1: the current cell is alive.
REQ-014 frame_end_in, input, 1: one-cycle pulse closing the current generation's count.
REQ-015 pix_out, output, 12: graph pixel colour; 12'h000 outside the graph.
REQ-016 last_count_out, output, CNT_W: the most recently committed raw frame count.
REQ-017 peak_count_out, output, CNT_W: the largest raw count committed since reset.

Function
REQ-018 The accumulator SHALL increment on each cycle with alive_valid_in && is_alive_in, saturating at 2^CNT_W-1.
REQ-019 On frame_end_in, the closing count SHALL include that same cycle's qualified alive sample.
REQ-020 On frame_end_in, the accumulator SHALL restart at 0, or at 1 if a qualified alive sample also arrives that cycle; no sample is lost or double-counted.
REQ-021 On frame_end_in, the block SHALL write h = min(count >> SCALE_SHIFT, HEIGHT) into history[wr_ptr].
REQ-022 On each commit, wr_ptr SHALL advance modulo DEPTH (DEPTH-1 -> 0), fill SHALL increment saturating at DEPTH, and last_count_out and peak_count_out SHALL update on the next edge.
REQ-023 History SHALL be a single-write, single-read synchronous RAM of DEPTH x 10 bits.
REQ-024 For plot column c = hcount_in - GRAPH_X - 1 (0..DEPTH-1), the read index SHALL be (wr_ptr - fill + c) mod DEPTH, so the oldest sample is leftmost and the newest is at c = fill-1.
REQ-025 Columns with c >= fill SHALL render no bar.
REQ-026 Pixel (h,v) SHALL be a bar pixel if it is in plot column c < fill, GRAPH_Y <= v < GRAPH_Y+HEIGHT, and GRAPH_Y+HEIGHT-1-v < history value.
REQ-027 The y-axis SHALL be h == GRAPH_X with GRAPH_Y <= v <= GRAPH_Y+HEIGHT, coloured 12'hFFF.
REQ-028 The x-axis SHALL be v == GRAPH_Y+HEIGHT with GRAPH_X <= h <= GRAPH_X+DEPTH, coloured 12'hFFF.
REQ-029 Axes SHALL take priority over bars; every other pixel SHALL be 12'h000.
REQ-030 pix_out SHALL have a fixed latency of exactly 2 cycles from hcount_in/vcount_in: stage 1 is address and region decode plus RAM read, stage 2 is compare and register.
REQ-031 A commit coinciding with a read of the same entry MAY return old or new data; the read SHALL still be deterministic and X-free.
REQ-032 The pipeline SHALL run continuously, with no start handshake; region checks SHALL use full-width unsigned compares with no wrap.

Reset
REQ-033 While rst_in is high: the accumulator, wr_ptr, fill, last_count_out and peak_count_out SHALL clear to 0, and pix_out SHALL be 12'h000.
REQ-034 Reset SHALL ignore frame_end_in and alive inputs during the reset cycle, and a reset mid-frame SHALL discard the partial count.
REQ-035 RAM contents need not clear, because fill = 0 masks all bars.
REQ-036 The first valid pix_out SHALL appear 2 cycles after rst_in deasserts.

Verification
REQ-037 Reset, then sweep one frame with no commits -> only axis pixels white (h=800 or v=300 in range), all else 12'h000, pix_out 2 cycles after coordinates.
REQ-038 Give 1000 qualified alive samples, then frame_end -> last_count_out=1000, bar height 62 (1000>>4) at column 801, rows 238..299 green, row 237 black.
REQ-039 Give frame_end together with a qualified alive sample, after 5 prior alives -> committed count 6, next frame starts at 1.
REQ-040 Commit 205 frames with count = 16*k (k = 1..205) -> wr_ptr wraps to 5, fill=200, leftmost column shows k=6 (height 6), rightmost shows height 200 (clamped), peak_count_out=3280.
REQ-041 Assert rst_in mid-frame after 50 alives, release, then frame_end -> last_count_out=0 and no bars visible.
REQ-042 Hold alive continuously for 2^16+10 cycles, then frame_end -> last_count_out=65535 and bar clamped to HEIGHT.
